// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one OBI memory port between fetch and LSU, routing in-order responses via a source-ID FIFO.
// Optional MEM_ARB_RR_EN selects round-robin arbitration instead of fixed data-side priority.
module mem_port_arbiter #(
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] PC_RESET        = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    input  logic        flush_i,
    output logic [2:0]  outstanding_o,
    output logic        spurious_o
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t      state, state_next;
    logic [2:0]  count;
    logic [1:0]  rptr, wptr;
    logic [3:0]  src_q, disc_q;
    logic        hold_instr, arb_instr, sel_instr, full, accept, pop, head_ok;
    logic        unused_pc;
    assign unused_pc = ^PC_RESET;

    function automatic logic [1:0] inc(input logic [1:0] p);
        return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
    endfunction

`ifdef MEM_ARB_RR_EN
    logic last_instr;
    assign arb_instr = instr_req_i & (~data_req_i | ~last_instr);
`else
    assign arb_instr = instr_req_i & ~data_req_i;
`endif

    assign full      = count == 3'(MAX_OUTSTANDING);
    assign sel_instr = (state == HOLD) ? hold_instr : arb_instr;
    assign mem_req_o = (instr_req_i | data_req_i) & ~full;
    assign accept    = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & (count != 3'd0);

    assign mem_addr_o  = sel_instr ? instr_addr_i : data_addr_i;
    assign mem_we_o    = ~sel_instr & data_we_i;
    assign mem_be_o    = sel_instr ? 4'hF : data_be_i;
    assign mem_wdata_o = sel_instr ? 32'h0 : data_wdata_i;

    assign instr_gnt_o = accept & sel_instr;
    assign data_gnt_o  = accept & ~sel_instr;

    // Discarded heads are popped but produce no response on either side.
    assign head_ok        = pop & ~disc_q[rptr];
    assign instr_rvalid_o = head_ok & src_q[rptr];
    assign data_rvalid_o  = head_ok & ~src_q[rptr];
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign outstanding_o  = count;

    always_comb begin
        state_next = state;
        state_next = (state == IDLE) ? ((mem_req_o & ~mem_gnt_i) ? HOLD : IDLE)
                                     : (mem_gnt_i ? IDLE : HOLD);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            hold_instr <= 1'b0;
            count      <= 3'd0;
            rptr       <= 2'd0;
            wptr       <= 2'd0;
            src_q      <= 4'd0;
            disc_q     <= 4'd0;
            spurious_o <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_instr <= 1'b1;
`endif
        end else begin
            state <= state_next;
            if (state == IDLE) hold_instr <= arb_instr;
            disc_q <= flush_i ? (disc_q | src_q) : disc_q;
            if (accept) begin
                src_q[wptr]  <= sel_instr;
                disc_q[wptr] <= sel_instr & flush_i;
                wptr         <= inc(wptr);
            end
            if (pop) rptr <= inc(rptr);
            if (accept & ~pop) count <= count + 3'd1;
            else if (~accept & pop) count <= count - 3'd1;
            if (mem_rvalid_i & (count == 3'd0)) spurious_o <= 1'b1;
`ifdef MEM_ARB_RR_EN
            if (accept) last_instr <= sel_instr;
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner-case sequences and randomized run against a queue-based model.
module tb_mem_port_arbiter;
    localparam int MAX = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic ir, dr, dwe, mg, rv, merr, fl;
    logic [31:0] ia, da, dwd, rd;
    logic [3:0] dbe;
    logic igt, irv, ierr, dgt, drv, derr, mreq, mwe, spur;
    logic [31:0] irdata, drdata, maddr, mwdata;
    logic [3:0] mbe;
    logic [2:0] outst;

    mem_port_arbiter #(.MAX_OUTSTANDING(MAX), .PC_RESET(32'h0)) dut (
        .clk(clk), .rstn(rstn),
        .instr_req_i(ir), .instr_addr_i(ia), .instr_gnt_o(igt), .instr_rvalid_o(irv),
        .instr_rdata_o(irdata), .instr_err_o(ierr),
        .data_req_i(dr), .data_addr_i(da), .data_we_i(dwe), .data_be_i(dbe), .data_wdata_i(dwd),
        .data_gnt_o(dgt), .data_rvalid_o(drv), .data_rdata_o(drdata), .data_err_o(derr),
        .mem_req_o(mreq), .mem_addr_o(maddr), .mem_we_o(mwe), .mem_be_o(mbe), .mem_wdata_o(mwdata),
        .mem_gnt_i(mg), .mem_rvalid_i(rv), .mem_rdata_i(rd), .mem_err_i(merr),
        .flush_i(fl), .outstanding_o(outst), .spurious_o(spur)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ir = 0; ia = 0; dr = 0; da = 0; dwe = 0; dbe = 0; dwd = 0;
        mg = 0; rv = 0; rd = 0; merr = 0; fl = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1;
        #2;
        chk("reset_handshake", {29'd0, mreq, igt, dgt}, 0);
        chk("reset_resp", {28'd0, irv, drv, ierr, derr}, 0);
        chk("reset_outstanding", outst, 0);
        chk("reset_spurious", spur, 0);
    endtask

    typedef struct {
        logic ir; logic [31:0] ia; logic dr; logic [31:0] da;
        logic mg; logic rv; logic [31:0] rd; logic fl;
        logic xreq; logic [31:0] xaddr; logic xigt; logic xdgt;
        logic xirv; logic xdrv; logic [2:0] xout;
    } vec_t;
    vec_t vecs[16];

    typedef struct packed { logic instr; logic disc; } ent_t;
    ent_t q[$];

    initial begin
        rstn = 1;
        idle_inputs();
        vecs[0]  = '{1, 32'h200, 1, 32'h100, 1, 0, 32'h0,  0, 1, 32'h100, 0, 1, 0, 0, 3'd0};
        vecs[1]  = '{1, 32'h200, 0, 32'h0,   1, 0, 32'h0,  0, 1, 32'h200, 1, 0, 0, 0, 3'd1};
        vecs[2]  = '{1, 32'h204, 0, 32'h0,   1, 0, 32'h0,  0, 0, 32'h0,   0, 0, 0, 0, 3'd2};
        vecs[3]  = '{1, 32'h204, 0, 32'h0,   1, 1, 32'hA,  0, 0, 32'h0,   0, 0, 0, 1, 3'd2};
        vecs[4]  = '{1, 32'h204, 0, 32'h0,   1, 1, 32'hB,  0, 1, 32'h204, 1, 0, 1, 0, 3'd1};
        vecs[5]  = '{0, 32'h0,   0, 32'h0,   0, 1, 32'hC,  0, 0, 32'h0,   0, 0, 1, 0, 3'd1};
        vecs[6]  = '{1, 32'h300, 0, 32'h0,   1, 0, 32'h0,  0, 1, 32'h300, 1, 0, 0, 0, 3'd0};
        vecs[7]  = '{0, 32'h0,   1, 32'h104, 1, 0, 32'h0,  1, 1, 32'h104, 0, 1, 0, 0, 3'd1};
        vecs[8]  = '{1, 32'h308, 0, 32'h0,   1, 1, 32'hA,  0, 0, 32'h0,   0, 0, 0, 0, 3'd2};
        vecs[9]  = '{1, 32'h308, 0, 32'h0,   1, 1, 32'hB,  0, 1, 32'h308, 1, 0, 0, 1, 3'd1};
        vecs[10] = '{0, 32'h0,   0, 32'h0,   0, 0, 32'h0,  1, 0, 32'h0,   0, 0, 0, 0, 3'd1};
        vecs[11] = '{0, 32'h0,   0, 32'h0,   0, 1, 32'hC,  0, 0, 32'h0,   0, 0, 0, 0, 3'd1};
        vecs[12] = '{0, 32'h0,   0, 32'h0,   0, 0, 32'h0,  0, 0, 32'h0,   0, 0, 0, 0, 3'd0};
        vecs[13] = '{1, 32'h400, 0, 32'h0,   1, 0, 32'h0,  1, 1, 32'h400, 1, 0, 0, 0, 3'd0};
        vecs[14] = '{0, 32'h0,   0, 32'h0,   0, 1, 32'hD,  0, 0, 32'h0,   0, 0, 0, 0, 3'd1};
        vecs[15] = '{0, 32'h0,   0, 32'h0,   0, 0, 32'h0,  0, 0, 32'h0,   0, 0, 0, 0, 3'd0};

        do_reset();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ir = vecs[k].ir; ia = vecs[k].ia; dr = vecs[k].dr; da = vecs[k].da;
            dbe = 4'hF; mg = vecs[k].mg; rv = vecs[k].rv; rd = vecs[k].rd; fl = vecs[k].fl;
            #2;
            chk($sformatf("vec%0d_req", k), mreq, vecs[k].xreq);
            if (vecs[k].xreq) chk($sformatf("vec%0d_addr", k), maddr, vecs[k].xaddr);
            chk($sformatf("vec%0d_gnt", k), {igt, dgt}, {vecs[k].xigt, vecs[k].xdgt});
            chk($sformatf("vec%0d_rvalid", k), {irv, drv}, {vecs[k].xirv, vecs[k].xdrv});
            chk($sformatf("vec%0d_rdata", k), drv ? drdata : irdata, vecs[k].rd);
            chk($sformatf("vec%0d_outstanding", k), outst, vecs[k].xout);
        end

        // Stall with instr selected: a late data request must not steal the handshake.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ir = (k < 4); ia = 32'h500; dr = (k >= 1); da = 32'h600; mg = (k >= 3);
            #2;
            chk($sformatf("hold%0d_addr", k), maddr, (k < 4) ? 32'h500 : 32'h600);
            chk($sformatf("hold%0d_gnt", k), {igt, dgt}, (k == 3) ? 2'b10 : (k == 4) ? 2'b01 : 2'b00);
        end

        // Response with nothing outstanding is dropped and latched as spurious.
        do_reset();
        @(negedge clk);
        rv = 1; rd = 32'hDEAD;
        #2;
        chk("spur_rvalid", {irv, drv}, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rv = 0;
            #2;
            chk($sformatf("spur_sticky%0d", k), spur, 1);
        end

        // Continuous contention: alternation under round-robin, data always under fixed priority.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ir = 1; ia = 32'h700; dr = 1; da = 32'h800; mg = 1; rv = (k > 0);
            #2;
`ifdef MEM_ARB_RR_EN
            chk($sformatf("contend%0d_gnt", k), {igt, dgt}, (k % 2) ? 2'b10 : 2'b01);
`else
            chk($sformatf("contend%0d_gnt", k), {igt, dgt}, 2'b01);
`endif
        end

        // Randomized run against the transaction-level model.
        do_reset();
        begin
            bit pend, pend_i, last_i, sp, i_acc, d_acc;
            pend = 0; pend_i = 0; last_i = 1; sp = 0; i_acc = 0; d_acc = 0;
            q.delete();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                bit full_m, ereq, who, eacc, epop, eirv, edrv;
                int sz;
                ent_t head;
                @(negedge clk);
                if (!ir || i_acc) begin ir = 1'($urandom_range(0, 1)); ia = $urandom; end
                if (!dr || d_acc) begin
                    dr = 1'($urandom_range(0, 1)); da = $urandom;
                    dwe = 1'($urandom_range(0, 1)); dbe = 4'($urandom); dwd = $urandom;
                end
                mg = ($urandom_range(0, 3) != 0);
                rv = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 200) == 0);
                rd = $urandom; merr = 1'($urandom_range(0, 1)); fl = ($urandom_range(0, 7) == 0);
                sz = q.size();
                full_m = (sz == MAX);
                ereq = (ir || dr) && !full_m;
                if (pend) who = pend_i;
`ifdef MEM_ARB_RR_EN
                else who = ir && (!dr || !last_i);
`else
                else who = ir && !dr;
`endif
                eacc = ereq && mg;
                epop = rv && sz > 0;
                head = epop ? q[0] : '0;
                eirv = epop && head.instr && !head.disc;
                edrv = epop && !head.instr && !head.disc;
                #2;
                chk("rnd_req", mreq, ereq);
                if (ereq) begin
                    chk("rnd_addr", maddr, who ? ia : da);
                    chk("rnd_ctrl", {mwe, mbe}, who ? 5'b01111 : {dwe, dbe});
                    chk("rnd_wdata", mwdata, who ? 32'h0 : dwd);
                end
                chk("rnd_gnt", {igt, dgt}, {eacc && who, eacc && !who});
                chk("rnd_rvalid", {irv, drv}, {eirv, edrv});
                chk("rnd_err", {ierr, derr}, {eirv && merr, edrv && merr});
                if (eirv) chk("rnd_irdata", irdata, rd);
                if (edrv) chk("rnd_drdata", drdata, rd);
                chk("rnd_outstanding", outst, sz);
                chk("rnd_spurious", spur, sp);
                if (epop) void'(q.pop_front());
                if (fl) foreach (q[k]) if (q[k].instr) q[k].disc = 1;
                if (eacc) begin q.push_back('{who, who && fl}); last_i = who; end
                if (rv && sz == 0) sp = 1;
                if (pend && mg) pend = 0;
                else if (!pend && ereq && !mg) begin pend = 1; pend_i = who; end
                i_acc = eacc && who;
                d_acc = eacc && !who;
            end
        end
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one OBI-style memory port (req/gnt/rvalid/err) between the fetch stage (instruction side) and the load/store unit (data side).
- Tracks up to MAX_OUTSTANDING in-flight transactions with a source-ID FIFO so that each in-order response returns to its originator.
- Supports flush of in-flight fetch responses on a PC change; discarded responses are consumed silently.
- Sits between the fetch/memory stages and the single-port memory or bus bridge.

Parameters:
- MAX_OUTSTANDING, 2, depth of the tracking FIFO; legal range 1..4.
- PC_RESET, 0, unused by datapath; kept for instantiation symmetry with the fetch stage.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch address
- instr_gnt_o  out  1  fetch request accepted
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch response data
- instr_err_o  out  1  fetch response error
- data_req_i  in  1  LSU request
- data_addr_i  in  32  LSU address
- data_we_i  in  1  LSU write enable
- data_be_i  in  4  LSU byte enables
- data_wdata_i  in  32  LSU write data
- data_gnt_o  out  1  LSU request accepted
- data_rvalid_o  out  1  LSU response valid
- data_rdata_o  out  32  LSU response data
- data_err_o  out  1  LSU response error
- mem_req_o  out  1  memory request
- mem_addr_o  out  32  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_wdata_o  out  32  memory write data
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory response data
- mem_err_i  in  1  memory response error
- flush_i  in  1  discard all outstanding fetch responses
- outstanding_o  out  3  current FIFO occupancy
- spurious_o  out  1  sticky flag: mem_rvalid_i seen with FIFO empty

Behaviour:
- Reset: FSM in IDLE, FIFO empty, priority pointer selects data side; outstanding_o=0, spurious_o=0, all gnt/rvalid/err outputs 0.
- full = (count == MAX_OUTSTANDING), registered count only. No grant is issued while full, even if a pop occurs in the same cycle.
- mem_req_o = (instr_req_i | data_req_i) & ~full.
- mem_addr_o/we/be/wdata are muxed from the selected source. When instr is selected: we=0, be=4'hF, wdata=0.
- FSM state IDLE:
  - sel comes from the arbitration rule.
  - mem_req_o & ~mem_gnt_i -> go to HOLD with sel latched.
  - A grant in this cycle -> stay in IDLE.
- FSM state HOLD:
  - sel is frozen at the latched source; no switching mid-handshake.
  - mem_gnt_i -> return to IDLE.
  - Requesters must hold req and address stable until gnt.
- Grant routing: x_gnt_o = mem_gnt_i & mem_req_o & (sel==x). Zero-cycle grant is combinational.
- Push: on each accepted grant, push entry {src, discard}. discard=1 if src=instr and flush_i is high in the same cycle.
- Pop: on mem_rvalid_i with FIFO non-empty, pop the head.
  - If head discard=0: assert rvalid of head src for that cycle, with rdata/err = mem_rdata_i/mem_err_i.
  - If head discard=1: no rvalid to either side.
- rdata outputs of both sides pass mem_rdata_i combinationally; only rvalid and err are gated.
- flush_i:
  - Sets discard on every valid FIFO entry with src=instr.
  - Data entries are unaffected.
  - A pending HOLD on instr is not aborted.
- Simultaneous push and pop: count unchanged; the pop acts on the old head and the push writes the tail.
- Responses are strictly in order; the FIFO is circular with wrap-around read/write pointers.
- mem_rvalid_i with FIFO empty: ignored, spurious_o <= 1 (sticky until reset).
- Latency: the arbiter adds 0 cycles on the request and response paths.
- Reset mid-transaction: everything returns to reset state; the memory side must also be reset.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both sides request in IDLE, grant the side not granted last.
  - The last-winner register updates on each accepted grant.
- Undefined: fixed priority, data side always wins in IDLE.

Test Plan:
- Both req at once, mem_gnt_i=1, data_addr=0x100, instr_addr=0x200 (fixed priority) -> mem_addr_o=0x100, data_gnt_o=1, instr_gnt_o=0; next cycle (data_req low) mem_addr_o=0x200.
- mem_gnt_i low for 3 cycles with instr selected, data_req rises in cycle 2 -> mem_addr_o stays instr_addr in all cycles; instr_gnt_o on gnt; data granted afterwards.
- MAX_OUTSTANDING=2: grant 2 instr requests with no rvalid -> third request gets no grant and mem_req_o=0, outstanding_o=2; one rvalid -> instr_rvalid_o=1, outstanding_o=1.
- Grants in order instr, data, instr; flush_i pulse; then 3 rvalids with rdata A,B,C -> only data_rvalid_o with B; no instr_rvalid_o.
- mem_rvalid_i=1 with FIFO empty -> no rvalid outputs, spurious_o=1, held until rstn.
- With MEM_ARB_RR_EN defined, both sides requesting continuously with gnt=1 -> grants alternate data, instr, data, instr.
